// File: rtl/serial_word_receiver_pkg.sv
// ----------------------------------------------------------------------------
// serial_link_pkg
// Purpose : constants shared by both ends of the serial shift link
//           (receiver and matching transmitter): FSM state encoding and
//           the line levels that frame a word.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package serial_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } link_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : serial_link_pkg

// File: rtl/serial_word_receiver_if.sv
// ----------------------------------------------------------------------------
// serial_word_receiver_if
// Purpose : valid/ready word bus between the receiver and its consumer.
// Signals : dout       - received word (driven by master)
//           dout_valid - dout holds an unconsumed word (driven by master)
//           dout_ready - consumer accepts dout (driven by slave)
// ----------------------------------------------------------------------------
interface serial_word_receiver_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface : serial_word_receiver_if

// File: rtl/serial_word_receiver_rx_shift_core.sv
// ----------------------------------------------------------------------------
// rx_shift_core
// Purpose : WIDTH-bit deserializing shifter plus data-bit counter. The shift
//           direction is captured at frame start so a change of i_msb_first
//           mid-frame cannot corrupt the word being assembled.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_clear       - frame start: zero shifter/count, latch direction
//           i_shift       - shift i_sin in and advance the count
//           i_msb_first   - direction to latch on i_clear
//           i_sin         - serial data bit
//           o_word        - current shifter contents
//           o_last        - count is at the final data bit (WIDTH-1)
// ----------------------------------------------------------------------------
module rx_shift_core
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_msb_first,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;

  // Shifter, bit counter and per-frame direction latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= {WIDTH{1'b0}};
      r_cnt <= {CW{1'b0}};
      r_dir <= 1'b0;
    end else if (i_clear) begin
      r_sh  <= {WIDTH{1'b0}};
      r_cnt <= {CW{1'b0}};
      r_dir <= i_msb_first;
    end else if (i_shift) begin
      // MSB-first enters at bit 0 and walks left; LSB-first enters at the top
      if (r_dir) begin
        r_sh <= {r_sh[WIDTH-2:0], i_sin};
      end else begin
        r_sh <= {i_sin, r_sh[WIDTH-1:1]};
      end
      // Saturate at the final data bit; the next frame start clears it
      if (r_cnt != LAST_CNT) begin
        r_cnt <= r_cnt + ONE_CNT;
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_sh  <= r_sh;
      r_cnt <= r_cnt;
      r_dir <= r_dir;
    end
  end

  assign o_word = r_sh;
  assign o_last = (r_cnt == LAST_CNT);

endmodule : rx_shift_core

// File: rtl/serial_word_receiver.sv
// ----------------------------------------------------------------------------
// serial_word_receiver
// Purpose : receive end of the serial shift link. Frames are
//           start(0) + WIDTH data bits + stop(1), idle line high; the line is
//           sampled only on sin_en strobes. Completed words go to a one-word
//           holding register presented on a valid/ready bus.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           sin        - serial data line
//           sin_en     - bit strobe
//           msb_first  - 1: first data bit lands in dout[WIDTH-1]
//           out_if     - master side of the dout/dout_valid/dout_ready bus
//           busy       - frame in progress
//           frame_err  - one-cycle pulse: stop bit sampled low, word dropped
//           overrun    - one-cycle pulse: holding register full, word dropped
// ----------------------------------------------------------------------------
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  input  logic                   sin_en,
  input  logic                   msb_first,
  serial_word_receiver_if.master out_if,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun
);

  link_state_t      r_state;
  link_state_t      w_next_state;
  logic             w_clear;
  logic             w_shift;
  logic             w_deliver;
  logic             w_stop_bad;
  logic             w_can_load;
  logic [WIDTH-1:0] w_word;
  logic             w_last;

  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;

  rx_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_shift     (w_shift),
    .i_msb_first (msb_first),
    .i_sin       (sin),
    .o_word      (w_word),
    .o_last      (w_last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and strobe-qualified control decode
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_deliver    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sin_en && (sin == START_BIT)) begin
          w_next_state = ST_DATA;
          w_clear      = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (sin_en) begin
          w_shift = 1'b1;
          if (w_last) begin
            w_next_state = ST_STOP;
          end else begin
            w_next_state = ST_DATA;
          end
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_STOP: begin
        if (sin_en) begin
          w_next_state = ST_IDLE;
          if (sin == STOP_BIT) begin
            w_deliver = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end else begin
          w_next_state = ST_STOP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Holding register is free if empty or being drained this same cycle
  assign w_can_load = !r_dout_valid || out_if.dout_ready;

  // Holding register, handshake and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= {WIDTH{1'b0}};
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_busy      <= (w_next_state != ST_IDLE);
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_deliver && !w_can_load;
      if (w_deliver && w_can_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && out_if.dout_ready) begin
        r_dout       <= r_dout;
        r_dout_valid <= 1'b0;
      end else begin
        r_dout       <= r_dout;
        r_dout_valid <= r_dout_valid;
      end
    end
  end

  assign out_if.dout       = r_dout;
  assign out_if.dout_valid = r_dout_valid;
  assign busy              = r_busy;
  assign frame_err         = r_frame_err;
  assign overrun           = r_overrun;

endmodule : serial_word_receiver

// File: tb/tb_serial_word_receiver.sv
// ----------------------------------------------------------------------------
// tb_serial_word_receiver
// Purpose : directed self-checking bench for serial_word_receiver, WIDTH=4.
//           Inputs change 1 time unit after posedge; outputs are sampled at
//           the same point, i.e. they reflect the most recent edge.
// ----------------------------------------------------------------------------
module tb_serial_word_receiver;

  logic clk = 1'b0;
  logic rst;
  logic sin;
  logic sin_en;
  logic msb_first;
  logic busy;
  logic frame_err;
  logic overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WIDTH(4)) u_if ();

  serial_word_receiver #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .msb_first (msb_first),
    .out_if    (u_if.master),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    sin    = b;
    sin_en = 1'b1;
    tick();
  endtask

  task automatic idle();
    sin    = 1'b1;
    sin_en = 1'b0;
    tick();
  endtask

  // start bit followed by d[3] .. d[0] in time order
  task automatic send_head(input logic [3:0] d);
    strobe(1'b0);
    for (int i = 3; i >= 0; i--) strobe(d[i]);
  endtask

  task automatic consume();
    u_if.dout_ready = 1'b1;
    idle();
    u_if.dout_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] stream;
    logic       b;
    rst             = 1'b1;
    sin             = 1'b1;
    sin_en          = 1'b0;
    msb_first       = 1'b1;
    u_if.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_dout",  {28'd0, u_if.dout}, 32'h0);
    check("rst_valid", {31'd0, u_if.dout_valid}, 32'h0);
    check("rst_busy",  {31'd0, busy}, 32'h0);
    check("rst_ferr",  {31'd0, frame_err}, 32'h0);
    check("rst_ovr",   {31'd0, overrun}, 32'h0);
    rst = 1'b0;
    idle();

    // 1: MSB-first 1010
    msb_first = 1'b1;
    send_head(4'b1010);
    check("s1_busy_pre_stop",  {31'd0, busy}, 32'h1);
    check("s1_valid_pre_stop", {31'd0, u_if.dout_valid}, 32'h0);
    strobe(1'b1);
    check("s1_dout",  {28'd0, u_if.dout}, 32'hA);
    check("s1_valid", {31'd0, u_if.dout_valid}, 32'h1);
    check("s1_busy",  {31'd0, busy}, 32'h0);
    check("s1_ferr",  {31'd0, frame_err}, 32'h0);
    consume();
    check("s1_drained", {31'd0, u_if.dout_valid}, 32'h0);

    // 2: LSB-first, same stream; direction change mid-frame must be ignored
    msb_first = 1'b0;
    strobe(1'b0);
    check("s2_busy_start", {31'd0, busy}, 32'h1);
    msb_first = 1'b1;
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    check("s2_busy_pre_stop", {31'd0, busy}, 32'h1);
    strobe(1'b1);
    check("s2_dout",  {28'd0, u_if.dout}, 32'h5);
    check("s2_valid", {31'd0, u_if.dout_valid}, 32'h1);
    check("s2_busy",  {31'd0, busy}, 32'h0);
    consume();

    // 3: bad stop bit, then a good frame
    msb_first = 1'b1;
    send_head(4'b0110);
    strobe(1'b0);
    check("s3_ferr",  {31'd0, frame_err}, 32'h1);
    check("s3_valid", {31'd0, u_if.dout_valid}, 32'h0);
    check("s3_ovr",   {31'd0, overrun}, 32'h0);
    check("s3_busy",  {31'd0, busy}, 32'h0);
    idle();
    check("s3_ferr_pulse", {31'd0, frame_err}, 32'h0);
    send_head(4'b1100);
    strobe(1'b1);
    check("s3_dout",  {28'd0, u_if.dout}, 32'hC);
    check("s3_valid2", {31'd0, u_if.dout_valid}, 32'h1);
    consume();

    // 4: overrun with consumer stalled, then simultaneous drain and load
    send_head(4'b1010);
    strobe(1'b1);
    check("s4_dout_first", {28'd0, u_if.dout}, 32'hA);
    send_head(4'b0110);
    strobe(1'b1);
    check("s4_ovr",       {31'd0, overrun}, 32'h1);
    check("s4_dout_held", {28'd0, u_if.dout}, 32'hA);
    check("s4_valid",     {31'd0, u_if.dout_valid}, 32'h1);
    check("s4_ferr",      {31'd0, frame_err}, 32'h0);
    idle();
    check("s4_ovr_pulse", {31'd0, overrun}, 32'h0);
    check("s4_dout_still", {28'd0, u_if.dout}, 32'hA);
    send_head(4'b0110);
    u_if.dout_ready = 1'b1;
    strobe(1'b1);
    u_if.dout_ready = 1'b0;
    check("s4_no_ovr",  {31'd0, overrun}, 32'h0);
    check("s4_dout_new", {28'd0, u_if.dout}, 32'h6);
    check("s4_valid_new", {31'd0, u_if.dout_valid}, 32'h1);

    // 5: reset mid-frame with a word still held
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    rst    = 1'b1;
    sin    = 1'b1;
    sin_en = 1'b0;
    tick();
    rst = 1'b0;
    check("s5_dout",  {28'd0, u_if.dout}, 32'h0);
    check("s5_valid", {31'd0, u_if.dout_valid}, 32'h0);
    check("s5_busy",  {31'd0, busy}, 32'h0);
    check("s5_ferr",  {31'd0, frame_err}, 32'h0);
    check("s5_ovr",   {31'd0, overrun}, 32'h0);
    send_head(4'b0011);
    strobe(1'b1);
    check("s5_dout_after", {28'd0, u_if.dout}, 32'h3);
    consume();

    // 6: strobe every third cycle, line toggling in between
    msb_first = 1'b1;
    stream    = 6'b010101;
    for (int i = 5; i >= 0; i--) begin
      b      = stream[i];
      sin    = ~b;
      sin_en = 1'b0;
      tick();
      sin = b;
      tick();
      if (i == 5) check("s6_no_start_without_strobe", {31'd0, busy}, 32'h0);
      if (i == 1) check("s6_busy_between_strobes", {31'd0, busy}, 32'h1);
      strobe(b);
    end
    sin_en = 1'b0;
    check("s6_dout",  {28'd0, u_if.dout}, 32'hA);
    check("s6_valid", {31'd0, u_if.dout_valid}, 32'h1);
    check("s6_busy",  {31'd0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_word_receiver
